// File: rtl/cnn_conv.sv
`default_nettype none
// ============================================================================
// Module   : cnn_conv
// Purpose  : Sliding-window 2-D convolution of a small signed image with
//            NUM_FEATURES stored kernels. One output position (r,c) is
//            produced per clock for every kernel at once. The scan runs
//            column-fastest. Results are held in a registered feature map.
// Ports    : clk                - single clock, rising edge
//            rst_cnn            - sync active-high reset of FSM/datapath/outfmap
//            rst_weights        - sync active-high clear of the kernel memory
//            image_input        - signed 2-bit pixels [H][W], held during a run
//            weights_input      - one signed 2-bit kernel, row-major [K*K]
//            feature_writeAddr  - kernel slot to write
//            feature_WrEn       - active-low kernel write enable
//            convolution_enable - active-low start / hold request
//            outfmap            - signed 32-bit results [F][OH][OW]
//            done               - convolution complete
// Revision : 1.0 - initial release
// ============================================================================
module cnn_conv #(
  parameter int IMAGE_WIDTH  = 12,
  parameter int IMAGE_HEIGHT = 12,
  parameter int NUM_FEATURES = 1,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  localparam int OUTPUT_WIDTH  = (IMAGE_WIDTH  - KERNEL_SIZE) / STRIDE + 1,
  localparam int OUTPUT_HEIGHT = (IMAGE_HEIGHT - KERNEL_SIZE) / STRIDE + 1,
  localparam int ADDR_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_cnn,
  input  logic                    rst_weights,
  input  logic signed [1:0]       image_input [IMAGE_HEIGHT][IMAGE_WIDTH],
  input  logic signed [1:0]       weights_input [KERNEL_SIZE*KERNEL_SIZE],
  input  logic [ADDR_W-1:0]       feature_writeAddr,
  input  logic                    feature_WrEn,
  input  logic                    convolution_enable,
  output logic signed [31:0]      outfmap [NUM_FEATURES][OUTPUT_HEIGHT][OUTPUT_WIDTH],
  output logic                    done
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ROW_W = (OUTPUT_HEIGHT > 1) ? $clog2(OUTPUT_HEIGHT) : 1;
  localparam int COL_W = (OUTPUT_WIDTH  > 1) ? $clog2(OUTPUT_WIDTH)  : 1;
  localparam int IH_W  = (IMAGE_HEIGHT  > 1) ? $clog2(IMAGE_HEIGHT)  : 1;
  localparam int IW_W  = (IMAGE_WIDTH   > 1) ? $clog2(IMAGE_WIDTH)   : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic signed [1:0]  weights [NUM_FEATURES][KK];
  logic signed [31:0] conv_sum [NUM_FEATURES];

  // --------------------------------------------------------------------------
  // Kernel memory. Clear wins over a simultaneous write; out-of-range slots
  // are dropped so a non-power-of-two NUM_FEATURES never aliases.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_weights) begin
      for (int f = 0; f < NUM_FEATURES; f++) begin
        for (int k = 0; k < KK; k++) begin
          weights[f][k] <= '0;
        end
      end
    end else if (!feature_WrEn && (32'(feature_writeAddr) < NUM_FEATURES)) begin
      weights[feature_writeAddr] <= weights_input;
    end
  end

  // --------------------------------------------------------------------------
  // Window MAC for the current (row,col), all kernels in parallel. Operands
  // are sign-extended to 32 bits before the multiply.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [IH_W-1:0] pix_r;
    logic [IW_W-1:0] pix_c;
    pix_r = '0;
    pix_c = '0;
    for (int f = 0; f < NUM_FEATURES; f++) begin
      conv_sum[f] = '0;
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        for (int j = 0; j < KERNEL_SIZE; j++) begin
          pix_r = IH_W'(int'(row) * STRIDE + i);
          pix_c = IW_W'(int'(col) * STRIDE + j);
          conv_sum[f] = conv_sum[f]
                      + 32'(image_input[pix_r][pix_c]) * 32'(weights[f][i*KERNEL_SIZE+j]);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and result registers. done is raised on the first cycle
  // spent in DONE so it always appears for at least one cycle, then holds
  // until the start request is released.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_cnn) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      done  <= 1'b0;
      for (int f = 0; f < NUM_FEATURES; f++) begin
        for (int r = 0; r < OUTPUT_HEIGHT; r++) begin
          for (int c = 0; c < OUTPUT_WIDTH; c++) begin
            outfmap[f][r][c] <= '0;
          end
        end
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (!convolution_enable) begin
            row   <= '0;
            col   <= '0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          for (int f = 0; f < NUM_FEATURES; f++) begin
            outfmap[f][row][col] <= conv_sum[f];
          end
          if (col == COL_W'(OUTPUT_WIDTH - 1)) begin
            col <= '0;
            if (row == ROW_W'(OUTPUT_HEIGHT - 1)) begin
              row   <= '0;
              state <= DONE;
            end else begin
              row <= row + ROW_W'(1);
            end
          end else begin
            col <= col + COL_W'(1);
          end
        end
        DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else if (convolution_enable) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_conv
// Purpose  : Self-checking bench for cnn_conv (default parameters). Expected
//            feature maps come from a reference model in the bench and are
//            queued when a run is launched, then popped against outfmap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_conv;

  localparam int W  = 12;
  localparam int H  = 12;
  localparam int K  = 3;
  localparam int OW = 10;
  localparam int OH = 10;

  logic               clk;
  logic               rst_cnn;
  logic               rst_weights;
  logic signed [1:0]  image_input [H][W];
  logic signed [1:0]  weights_input [K*K];
  logic [0:0]         feature_writeAddr;
  logic               feature_WrEn;
  logic               convolution_enable;
  logic signed [31:0] outfmap [1][OH][OW];
  logic               done;

  int compared;
  int mismatched;
  int sb [$];
  int model_kernel [K*K];   // what the bench believes slot 0 holds

  cnn_conv dut (
    .clk                (clk),
    .rst_cnn            (rst_cnn),
    .rst_weights        (rst_weights),
    .image_input        (image_input),
    .weights_input      (weights_input),
    .feature_writeAddr  (feature_writeAddr),
    .feature_WrEn       (feature_WrEn),
    .convolution_enable (convolution_enable),
    .outfmap            (outfmap),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_image(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        image_input[r][c] = 2'(v);
  endtask

  // Write a kernel to a slot; model tracks only legal writes to slot 0.
  task automatic write_kernel(input int slot, input int k [K*K]);
    @(negedge clk);
    for (int i = 0; i < K*K; i++) weights_input[i] = 2'(k[i]);
    feature_writeAddr = 1'(slot);
    feature_WrEn = 1'b0;
    @(negedge clk);
    feature_WrEn = 1'b1;
    if (slot == 0) model_kernel = k;
  endtask

  function automatic int model_out(input int r, input int c);
    int acc;
    acc = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc += int'(image_input[r+i][c+j]) * model_kernel[i*K+j];
    return acc;
  endfunction

  // Queue the expected map, start, hold start until done, then score.
  task automatic run_conv(input string tag);
    int n;
    bit seen;
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        sb.push_back(model_out(r, c));
    @(negedge clk);
    convolution_enable = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    // first counted edge is the start edge itself
    check({tag, "_latency"}, n - 1, 101);
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        check(tag, outfmap[0][r][c], sb.pop_front());
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    convolution_enable = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, int'(done), 0);
  endtask

  function automatic int count_nonzero();
    int n;
    n = 0;
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        if (outfmap[0][r][c] != 0) n++;
    return n;
  endfunction

  int kx   [K*K];
  int kone [K*K];
  int snap;

  initial begin
    compared   = 0;
    mismatched = 0;
    kx   = '{1, -1, 1, -1, 1, -1, 1, -1, 1};
    kone = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    model_kernel = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    rst_cnn = 1'b1;
    rst_weights = 1'b1;
    feature_WrEn = 1'b1;
    feature_writeAddr = 1'b0;
    convolution_enable = 1'b1;
    for (int i = 0; i < K*K; i++) weights_input[i] = 2'sd0;
    fill_image(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_cnn = 1'b0;
    rst_weights = 1'b0;
    #1;
    check("reset_done", int'(done), 0);
    check("reset_outfmap_nonzero", count_nonzero(), 0);

    // All-ones image with kernel X -> every output is 1.
    write_kernel(0, kx);
    // slot 1 does not exist; must not disturb slot 0
    write_kernel(1, kone);
    run_conv("ones");
    check("ones_corner", outfmap[0][9][9], 1);

    // Holding start low in DONE must not restart; release drops done.
    snap = outfmap[0][5][5];
    repeat (5) begin
      @(posedge clk);
      #1;
      check("hold_done", int'(done), 1);
    end
    release_start("hold");
    check("hold_retained", outfmap[0][5][5], snap);

    fill_image(-2);
    run_conv("neg2");
    release_start("neg2");
    fill_image(-1);
    run_conv("neg1");
    release_start("neg1");

    // Single impulse at [1][1].
    fill_image(0);
    image_input[1][1] = 2'sd1;
    run_conv("impulse");
    check("imp_00", outfmap[0][0][0], 1);
    check("imp_01", outfmap[0][0][1], -1);
    check("imp_10", outfmap[0][1][0], -1);
    check("imp_11", outfmap[0][1][1], 1);
    release_start("impulse");

    // Reset mid-run clears everything and returns to IDLE.
    fill_image(1);
    @(negedge clk);
    convolution_enable = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_cnn = 1'b1;
    convolution_enable = 1'b1;
    @(negedge clk);
    rst_cnn = 1'b0;
    check("midrst_done", int'(done), 0);
    check("midrst_nonzero", count_nonzero(), 0);
    repeat (120) @(posedge clk);
    #1;
    check("midrst_idle_done", int'(done), 0);
    check("midrst_idle_nonzero", count_nonzero(), 0);
    run_conv("restart");
    release_start("restart");

    // Weight clear beats a simultaneous write.
    @(negedge clk);
    for (int i = 0; i < K*K; i++) weights_input[i] = 2'(kx[i]);
    feature_writeAddr = 1'b0;
    feature_WrEn = 1'b0;
    rst_weights = 1'b1;
    @(negedge clk);
    feature_WrEn = 1'b1;
    rst_weights = 1'b0;
    model_kernel = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    check("wrst_outfmap_kept", outfmap[0][3][3], 1);
    run_conv("wclear");
    release_start("wclear");

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
